// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default payload width,
// common to the receiver and transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is parameterised so idle-high lines do not glitch out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: mid-bit sampling, LSB-first payload, one-cycle
// FIFO write strobe plus done / framing-error / overrun status pulses.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 wr_en,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;
  logic                 pend_good;
  logic                 pend_ovr;
  logic                 pend_ferr;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // The stop-bit outcome is latched into pend_* and published one cycle later;
  // the FSM itself is already back in IDLE so a following start bit is not missed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      armed     <= 1'b0;
      pend_good <= 1'b0;
      pend_ovr  <= 1'b0;
      pend_ferr <= 1'b0;
      data_in   <= '0;
      wr_en     <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_en     <= pend_good;
      overrun   <= pend_ovr;
      frame_err <= pend_ferr;
      rx_done   <= pend_good | pend_ovr | pend_ferr;
      if (pend_good) begin
        data_in <= shreg;
      end
      pend_good <= 1'b0;
      pend_ovr  <= 1'b0;
      pend_ferr <= 1'b0;

      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          // armed requires the line to be seen high first, so a line held
          // low across reset release is not mistaken for a start bit.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DATA: begin
          if (timer == T_FULL) begin
            timer <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == I_LAST) begin
              bit_idx <= '0;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (rx_s) begin
              pend_good <= ~fifo_full;
              pend_ovr  <= fifo_full;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              pend_ferr <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          timer <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed, table-driven bench for uart_rx_deser at 16 clocks per bit.
module tb_uart_rx_deser;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int FRAME_CYC = (DB + 2) * CPB;
  localparam int EXP_LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx = 1'b1;
  logic          fifo_full = 1'b0;
  logic [DB-1:0] data_in;
  logic          wr_en, rx_done, frame_err, overrun, busy;

  uart_rx_deser #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .fifo_full (fifo_full),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_wr = 0, n_done = 0, n_ferr = 0, n_ovr = 0, n_consec = 0;
  int wr_cyc = 0, t0 = 0;
  logic prev_wr = 1'b0;
  logic [DB-1:0] wq[$];

  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      wq.push_back(data_in);
      wr_cyc = cyc;
      if (prev_wr) n_consec++;
    end
    if (rx_done)   n_done++;
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
    prev_wr = wr_en;
  end

  int total = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input logic stop, input int ncyc);
    logic [DB+1:0] fv;
    fv = {stop, d, 1'b0};
    t0 = cyc + 1;
    for (int i = 0; i < ncyc; i++) begin
      rx = (i < FRAME_CYC) ? fv[i / CPB] : stop;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_in"},   32'(data_in), 32'h0);
    check({tag, "_wr_en"},     32'(wr_en), 32'h0);
    check({tag, "_rx_done"},   32'(rx_done), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"},   32'(overrun), 32'h0);
    check({tag, "_busy"},      32'(busy), 32'h0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       full;
    int         hold;
    int         e_wr;
    int         e_done;
    int         e_ferr;
    int         e_ovr;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt[3];

  initial begin
    int s_wr, s_done, s_ferr, s_ovr;

    vt[0] = '{8'hA5, 1'b1, 1'b0, 0,  1, 1, 0, 0, 8'hA5};
    vt[1] = '{8'h3C, 1'b0, 1'b0, 40, 0, 1, 1, 0, 8'hA5};
    vt[2] = '{8'h5A, 1'b1, 1'b1, 0,  0, 1, 0, 1, 8'hA5};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    idle(5);

    for (int i = 0; i < 3; i++) begin
      s_wr = n_wr; s_done = n_done; s_ferr = n_ferr; s_ovr = n_ovr;
      fifo_full = vt[i].full;
      drive_frame(vt[i].d, vt[i].stop, FRAME_CYC);
      fifo_full = 1'b0;
      if (vt[i].hold > 0) begin
        rx = 1'b0;
        repeat (vt[i].hold) @(posedge clk);
        #1;
        check($sformatf("v%0d_busy_held", i), 32'(busy), 32'h1);
      end
      idle(20);
      check($sformatf("v%0d_wr_en", i),     n_wr - s_wr,     vt[i].e_wr);
      check($sformatf("v%0d_rx_done", i),   n_done - s_done, vt[i].e_done);
      check($sformatf("v%0d_frame_err", i), n_ferr - s_ferr, vt[i].e_ferr);
      check($sformatf("v%0d_overrun", i),   n_ovr - s_ovr,   vt[i].e_ovr);
      check($sformatf("v%0d_data_in", i),   32'(data_in),    32'(vt[i].e_data));
      check($sformatf("v%0d_busy_end", i),  32'(busy),       32'h0);
      if (i == 0) check("latency", wr_cyc - t0, EXP_LAT);
    end

    // Back-to-back frames with no idle gap
    wq.delete();
    s_wr = n_wr;
    drive_frame(8'h00, 1'b1, FRAME_CYC);
    drive_frame(8'hFF, 1'b1, FRAME_CYC);
    idle(20);
    check("b2b_count", n_wr - s_wr, 2);
    check("b2b_first",  (wq.size() > 0) ? 32'(wq[0]) : 32'hDEAD, 32'h00);
    check("b2b_second", (wq.size() > 1) ? 32'(wq[1]) : 32'hDEAD, 32'hFF);

    // Short glitch is a false start
    s_wr = n_wr; s_done = n_done; s_ferr = n_ferr;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("glitch_wr_en", n_wr - s_wr, 0);
    check("glitch_rx_done", n_done - s_done, 0);
    check("glitch_frame_err", n_ferr - s_ferr, 0);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_data_in", 32'(data_in), 32'hFF);

    // Reset asserted mid-frame aborts with no pulses
    s_wr = n_wr; s_done = n_done; s_ferr = n_ferr; s_ovr = n_ovr;
    drive_frame(8'h55, 1'b1, 50);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("midrst");
    rst = 1'b1;
    idle(5);
    check("midrst_pulses", (n_wr - s_wr) + (n_done - s_done) + (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
    s_wr = n_wr;
    drive_frame(8'h81, 1'b1, FRAME_CYC);
    idle(20);
    check("post_rst_wr_en", n_wr - s_wr, 1);
    check("post_rst_data_in", 32'(data_in), 32'h81);

    check("wr_en_consecutive", n_consec, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
